// File: rtl/input_preprocess_if.sv
// Button and switch bundle for input_preprocess: raw inputs in, action pulses and game level out.
interface input_preprocess_if;
    logic        btnL;
    logic        btnR;
    logic [15:0] SW;
    logic        move_left;
    logic        move_right;
    logic        start_game;
    logic        reset_table;
    logic        done_and_next;
    logic        draw_and_next;
    logic        game_started;

    modport master (
        output btnL, btnR, SW,
        input  move_left, move_right, start_game, reset_table,
               done_and_next, draw_and_next, game_started
    );

    modport slave (
        input  btnL, btnR, SW,
        output move_left, move_right, start_game, reset_table,
               done_and_next, draw_and_next, game_started
    );
endinterface

// File: rtl/input_preprocess.sv
// Synchronize, debounce and edge-detect buttons/switches into single-cycle game pulses.
// Optional move-button auto-repeat is enabled with macro BTN_AUTOREPEAT_EN.
module input_preprocess #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                interboard_rst,
    input_preprocess_if.slave   io
);
    localparam int N_IN  = 6;
    localparam int MAX_A = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Channel order: 0 btnL, 1 btnR, 2 SW[0], 3 SW[1], 4 SW[2], 5 SW[15]
    localparam int CH_L = 0, CH_R = 1, CH_RT = 2, CH_DN = 3, CH_DR = 4, CH_ST = 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync_p0, sync_p1;
    logic             vld_p0, vld_p1;
    logic [N_IN-1:0]  deb_p2, deb_p3;
    logic [N_IN-1:0]  armed;
    logic [CNT_W-1:0] deb_cnt [N_IN];
    logic [N_IN-1:0]  rise;
    logic [1:0]       rep_fire;

    logic move_left_r, move_right_r, start_game_r;
    logic reset_table_r, done_and_next_r, draw_and_next_r, game_started_r;

    assign raw = {io.SW[15], io.SW[2], io.SW[1], io.SW[0], io.btnR, io.btnL};

    // Stage p0/p1: two-flop synchronizer; vld marks when p1 holds a real sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (interboard_rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
        end
    end

    // Stage p2/p3: debounce, delayed copy for edge detect, arming after a confirmed low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_p2 <= '0;
            deb_p3 <= '0;
            armed  <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
        end else if (interboard_rst) begin
            deb_p2 <= '0;
            deb_p3 <= '0;
            armed  <= '0;
            for (int i = 0; i < N_IN; i++) deb_cnt[i] <= '0;
        end else begin
            deb_p3 <= deb_p2;
            armed  <= armed | ({N_IN{vld_p1}} & ~sync_p1 & ~deb_p2);
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == deb_p2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    deb_p2[i]  <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= sat_inc(deb_cnt[i]);
                end
            end
        end
    end

    assign rise = armed & deb_p2 & ~deb_p3;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_cnt [2];
    logic [1:0]       rep_phase;
    logic [1:0]       rep_held;

    always_comb begin
        rep_held = '0;
        rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rep_held[i] = armed[i] & deb_p2[i] & deb_p3[i];
            rep_fire[i] = rep_held[i] &
                          (rep_phase[i] ? (rep_cnt[i] == REP_LAST) : (rep_cnt[i] == HOLD_LAST));
        end
    end

    // Repeat counters: first interval is the hold delay, later ones the repeat period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_phase <= '0;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else if (interboard_rst) begin
            rep_phase <= '0;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!rep_held[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= sat_inc(rep_cnt[i]);
                end
            end
        end
    end
`else
    assign rep_fire = 2'b00;
`endif

    // Stage p4: registered pulses with gating and action priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_left_r     <= 1'b0;
            move_right_r    <= 1'b0;
            start_game_r    <= 1'b0;
            reset_table_r   <= 1'b0;
            done_and_next_r <= 1'b0;
            draw_and_next_r <= 1'b0;
            game_started_r  <= 1'b0;
        end else if (interboard_rst) begin
            move_left_r     <= 1'b0;
            move_right_r    <= 1'b0;
            start_game_r    <= 1'b0;
            reset_table_r   <= 1'b0;
            done_and_next_r <= 1'b0;
            draw_and_next_r <= 1'b0;
            game_started_r  <= 1'b0;
        end else begin
            move_left_r     <= (rise[CH_L] | rep_fire[0]) & game_started_r;
            move_right_r    <= (rise[CH_R] | rep_fire[1]) & game_started_r;
            start_game_r    <= rise[CH_ST];
            reset_table_r   <= rise[CH_RT] & game_started_r;
            done_and_next_r <= rise[CH_DN] & ~rise[CH_RT] & game_started_r;
            draw_and_next_r <= rise[CH_DR] & ~rise[CH_RT] & ~rise[CH_DN] & game_started_r;
            game_started_r  <= game_started_r | rise[CH_ST];
        end
    end

    assign io.move_left     = move_left_r;
    assign io.move_right    = move_right_r;
    assign io.start_game    = start_game_r;
    assign io.reset_table   = reset_table_r;
    assign io.done_and_next = done_and_next_r;
    assign io.draw_and_next = draw_and_next_r;
    assign io.game_started  = game_started_r;
endmodule

// File: tb/tb_input_preprocess.sv
// Directed bench for input_preprocess with DEB=4, HOLD=20, REPEAT=5.
module tb_input_preprocess;
    localparam int DEB = 4, HOLD = 20, REP = 5;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic interboard_rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    input_preprocess_if io();

    input_preprocess #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .io(io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_ml = 0, n_mr = 0, n_sg = 0, n_rt = 0, n_dn = 0, n_dr = 0;
    int last_ml = -1, last_mr = -1, last_sg = -1, last_rt = -1, last_dn = -1, last_dr = -1;
    int ml_q[$];

    always @(negedge clk) begin
        if (io.move_left)     begin n_ml++; last_ml = cyc; ml_q.push_back(cyc); end
        if (io.move_right)    begin n_mr++; last_mr = cyc; end
        if (io.start_game)    begin n_sg++; last_sg = cyc; end
        if (io.reset_table)   begin n_rt++; last_rt = cyc; end
        if (io.done_and_next) begin n_dn++; last_dn = cyc; end
        if (io.draw_and_next) begin n_dr++; last_dr = cyc; end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({io.game_started, io.start_game, io.move_left, io.move_right,
                     io.reset_table, io.done_and_next, io.draw_and_next});
    endfunction

    int c, b_ml, b_mr, b_sg, b_rt, b_dn, b_dr, base;
    int offs[$];
    int exp_offs[$];

    task automatic snap();
        b_ml = n_ml; b_mr = n_mr; b_sg = n_sg; b_rt = n_rt; b_dn = n_dn; b_dr = n_dr;
    endtask

    initial begin
        io.btnL = 1'b0;
        io.btnR = 1'b0;
        io.SW   = '0;

        tick(3);
        chk("reset_outs", outs(), 0);
        rst = 1'b1;
        tick(5);

        // move pulses are blocked before the game starts
        snap();
        io.btnL = 1'b1; tick(10);
        io.btnL = 1'b0; tick(10);
        chk("pre_start_move", n_ml - b_ml, 0);

        // start the game
        snap();
        io.SW[15] = 1'b1; c = cyc;
        tick(12);
        chk("start_cnt", n_sg - b_sg, 1);
        chk("start_lat", last_sg - c, LAT);
        chk("started", int'(io.game_started), 1);

        // single press of btnL
        snap();
        io.btnL = 1'b1; c = cyc;
        tick(10);
        io.btnL = 1'b0;
        tick(10);
        chk("ml_cnt", n_ml - b_ml, 1);
        chk("ml_lat", last_ml - c, LAT);

        // both move buttons in the same cycle
        snap();
        io.btnL = 1'b1; io.btnR = 1'b1; c = cyc;
        tick(10);
        io.btnL = 1'b0; io.btnR = 1'b0;
        tick(10);
        chk("both_ml_cnt", n_ml - b_ml, 1);
        chk("both_mr_cnt", n_mr - b_mr, 1);
        chk("both_same_cyc", last_ml - last_mr, 0);
        chk("both_lat", last_mr - c, LAT);

        // bouncing btnR, accepted only after it settles
        snap();
        for (int k = 0; k < 6; k++) begin
            io.btnR = (k % 2 == 0);
            tick(2);
        end
        io.btnR = 1'b1; c = cyc;
        tick(10);
        io.btnR = 1'b0;
        tick(10);
        chk("bounce_cnt", n_mr - b_mr, 1);
        chk("bounce_lat", last_mr - c, LAT);

        // action priority
        snap();
        io.SW[0] = 1'b1; io.SW[1] = 1'b1; c = cyc;
        tick(10);
        io.SW[0] = 1'b0; io.SW[1] = 1'b0;
        tick(10);
        chk("rt_cnt", n_rt - b_rt, 1);
        chk("rt_lat", last_rt - c, LAT);
        chk("dn_dropped", n_dn - b_dn, 0);

        snap();
        io.SW[1] = 1'b1; tick(10);
        io.SW[1] = 1'b0; tick(10);
        chk("dn_alone", n_dn - b_dn, 1);

        snap();
        io.SW[1] = 1'b1; io.SW[2] = 1'b1; tick(10);
        io.SW[1] = 1'b0; io.SW[2] = 1'b0; tick(10);
        chk("dn_over_dr", n_dn - b_dn, 1);
        chk("dr_dropped", n_dr - b_dr, 0);

        snap();
        io.SW[2] = 1'b1; tick(10);
        io.SW[2] = 1'b0; tick(10);
        chk("dr_alone", n_dr - b_dr, 1);

        // held btnL: initial pulse and optional auto-repeat
`ifdef BTN_AUTOREPEAT_EN
        exp_offs = '{0, 20, 25, 30, 35};
`else
        exp_offs = '{0};
`endif
        io.btnL = 1'b1; c = cyc; base = c + LAT;
        tick(LAT + 40);
        offs = {};
        foreach (ml_q[k]) if (ml_q[k] >= base && ml_q[k] < base + 40) offs.push_back(ml_q[k] - base);
        chk("rep_cnt", offs.size(), exp_offs.size());
        foreach (exp_offs[j]) chk("rep_off", (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
        io.btnL = 1'b0;
        tick(20);

        // async reset with SW[15] held high: no start until it is cycled
        rst = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 0);
        tick(3);
        rst = 1'b1;
        snap();
        tick(15);
        chk("sw15_held_nostart", n_sg - b_sg, 0);
        chk("sw15_held_gs", int'(io.game_started), 0);
        io.SW[15] = 1'b0; tick(8);
        io.SW[15] = 1'b1; c = cyc;
        tick(12);
        chk("sw15_cycle_start", n_sg - b_sg, 1);
        chk("sw15_cycle_lat", last_sg - c, LAT);
        chk("sw15_cycle_gs", int'(io.game_started), 1);

        // remote reset in the middle of a SW[2] debounce
        snap();
        io.SW[2] = 1'b1;
        tick(4);
        interboard_rst = 1'b1;
        tick(1);
        chk("ib_rst_outs", outs(), 0);
        interboard_rst = 1'b0;
        tick(20);
        chk("ib_rst_no_draw", n_dr - b_dr, 0);
        chk("ib_rst_no_start", n_sg - b_sg, 0);
        chk("ib_rst_gs", int'(io.game_started), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
